// File: rtl/w80386_bus_pkg.sv
// Shared types for the core's valid/ready memory bus.
package w80386_bus_pkg;

    localparam int unsigned BUS_DATA_WIDTH    = 32;
    localparam int unsigned BUS_ADDRESS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } bus_state_t;

    // Where the held read result comes from between completed reads.
    typedef enum logic [1:0] {
        READ_ZERO,
        READ_RAM,
        READ_OPEN
    } read_source_t;

    typedef struct packed {
        logic                         write_enable;
        logic [BUS_ADDRESS_WIDTH-1:0] address;
        logic [BUS_DATA_WIDTH-1:0]    write_data;
    } bus_request_t;

endpackage

// File: rtl/w80386_sram_1rw.sv
// Single-port synchronous word RAM: one read or one write per cycle, registered read.
module w80386_sram_1rw #(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     enable,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [DATA_WIDTH-1:0]    read_data
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // read_data only changes on a read, so it holds the last read word
    always_ff @(posedge clock) begin
        if (enable) begin
            if (write_enable) begin
                mem[address] <= write_data;
            end else begin
                read_data <= mem[address];
            end
        end
    end

endmodule

// File: rtl/w80386_bus_ram_responder.sv
// Bus responder: wait-state FSM in front of an on-chip word RAM, with window error flag.
module w80386_bus_ram_responder
    import w80386_bus_pkg::*;
#(
    parameter int unsigned WORD_ADDRESS_WIDTH = 10,
    parameter logic [31:0] BASE_ADDRESS       = 32'h0000_0000,
    parameter int unsigned WAIT_STATES        = 1,
    parameter logic [31:0] OPEN_BUS_DATA      = 32'hFFFF_FFFF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         bus_vaild,
    output logic                         bus_ready,
    input  logic                         bus_write_enable,
    input  logic [BUS_ADDRESS_WIDTH-1:0] bus_address,
    output logic [BUS_DATA_WIDTH-1:0]    bus_read_data,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_write_data,
    output logic                         bus_error
);

    localparam int unsigned COUNT_WIDTH = 4;
    localparam logic [BUS_ADDRESS_WIDTH-1:0] RAM_WORDS =
        BUS_ADDRESS_WIDTH'(1) << WORD_ADDRESS_WIDTH;

    bus_request_t                  request_c;
    logic [BUS_ADDRESS_WIDTH-1:0]  live_offset;
    logic                          live_in_window;
    logic [WORD_ADDRESS_WIDTH-1:0] live_word;

    bus_state_t                    state_q, state_d;
    logic [COUNT_WIDTH-1:0]        count_q, count_d;
    logic                          write_q, write_d;
    logic [WORD_ADDRESS_WIDTH-1:0] word_q, word_d;
    logic [BUS_DATA_WIDTH-1:0]     data_q, data_d;
    logic                          in_window_q, in_window_d;
    logic                          ready_q, ready_d;
    logic                          error_q, error_d;
    read_source_t                  source_q, source_d;

    logic                          ram_enable;
    logic                          ram_write;
    logic [WORD_ADDRESS_WIDTH-1:0] ram_address;
    logic [BUS_DATA_WIDTH-1:0]     ram_read_data;

    assign request_c = '{write_enable: bus_write_enable,
                         address:      bus_address,
                         write_data:   bus_write_data};

    // Unsigned offset: addresses below the base wrap high and fall out of window
    assign live_offset    = request_c.address - BASE_ADDRESS;
    assign live_in_window = (live_offset >> 2) < RAM_WORDS;
    assign live_word      = live_offset[WORD_ADDRESS_WIDTH+1:2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            write_q     <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            in_window_q <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            source_q    <= READ_ZERO;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            write_q     <= write_d;
            word_q      <= word_d;
            data_q      <= data_d;
            in_window_q <= in_window_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            source_q    <= source_d;
        end
    end

    // Next state; the RAM read is issued in the cycle before RESPOND
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        write_d     = write_q;
        word_d      = word_q;
        data_d      = data_q;
        in_window_d = in_window_q;
        ready_d     = 1'b0;
        error_d     = 1'b0;
        source_d    = source_q;
        ram_enable  = 1'b0;
        ram_write   = 1'b0;
        ram_address = word_q;

        case (state_q)
            IDLE: begin
                if (bus_vaild) begin
                    write_d     = request_c.write_enable;
                    word_d      = live_word;
                    data_d      = request_c.write_data;
                    in_window_d = live_in_window;
                    if (WAIT_STATES == 0) begin
                        state_d     = RESPOND;
                        ready_d     = 1'b1;
                        error_d     = !live_in_window;
                        ram_address = live_word;
                        if (!request_c.write_enable) begin
                            source_d   = live_in_window ? READ_RAM : READ_OPEN;
                            ram_enable = live_in_window;
                        end
                    end else begin
                        count_d = COUNT_WIDTH'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count_q != '0) begin
                    count_d = count_q - COUNT_WIDTH'(1);
                end else begin
                    state_d = RESPOND;
                    ready_d = 1'b1;
                    error_d = !in_window_q;
                    if (!write_q) begin
                        source_d   = in_window_q ? READ_RAM : READ_OPEN;
                        ram_enable = in_window_q;
                    end
                end
            end
            RESPOND: begin
                state_d    = IDLE;
                ram_enable = write_q && in_window_q;
                ram_write  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    w80386_sram_1rw #(
        .ADDRESS_WIDTH(WORD_ADDRESS_WIDTH),
        .DATA_WIDTH   (BUS_DATA_WIDTH)
    ) u_sram (
        .clock       (clock),
        .enable      (ram_enable),
        .write_enable(ram_write),
        .address     (ram_address),
        .write_data  (data_q),
        .read_data   (ram_read_data)
    );

    always_comb begin
        case (source_q)
            READ_RAM:  bus_read_data = ram_read_data;
            READ_OPEN: bus_read_data = OPEN_BUS_DATA;
            default:   bus_read_data = '0;
        endcase
    end

    assign bus_ready = ready_q;
    assign bus_error = error_q;

    // Initiator must hold bus_vaild until it samples bus_ready
    assert property (@(posedge clock) disable iff (!reset) (state_q == WAIT) |-> bus_vaild)
        else $warning("bus_vaild dropped while a transaction was pending");

endmodule

// File: tb/tb_w80386_bus_ram_responder.sv
// Randomised bench for w80386_bus_ram_responder: four configurations against a word-array model.
module tb_w80386_bus_ram_responder;

    localparam int N     = 4;
    localparam int DEPTH = 1024;
    localparam int unsigned WS0 = 1, WS1 = 0, WS2 = 5, WS3 = 15;
    localparam logic [31:0] B0 = 32'h0, B1 = 32'h0, B2 = 32'h1000, B3 = 32'h0;
    localparam logic [31:0] OPEN = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [N];
    logic        vld   [N];
    logic        rdy   [N];
    logic        wen   [N];
    logic [31:0] adr   [N];
    logic [31:0] rdat  [N];
    logic [31:0] wdat  [N];
    logic        err   [N];

    w80386_bus_ram_responder #(.WORD_ADDRESS_WIDTH(10), .BASE_ADDRESS(B0), .WAIT_STATES(WS0), .OPEN_BUS_DATA(OPEN)) u0 (
        .clock(clk), .reset(rst_n[0]), .bus_vaild(vld[0]), .bus_ready(rdy[0]), .bus_write_enable(wen[0]),
        .bus_address(adr[0]), .bus_read_data(rdat[0]), .bus_write_data(wdat[0]), .bus_error(err[0]));
    w80386_bus_ram_responder #(.WORD_ADDRESS_WIDTH(10), .BASE_ADDRESS(B1), .WAIT_STATES(WS1), .OPEN_BUS_DATA(OPEN)) u1 (
        .clock(clk), .reset(rst_n[1]), .bus_vaild(vld[1]), .bus_ready(rdy[1]), .bus_write_enable(wen[1]),
        .bus_address(adr[1]), .bus_read_data(rdat[1]), .bus_write_data(wdat[1]), .bus_error(err[1]));
    w80386_bus_ram_responder #(.WORD_ADDRESS_WIDTH(10), .BASE_ADDRESS(B2), .WAIT_STATES(WS2), .OPEN_BUS_DATA(OPEN)) u2 (
        .clock(clk), .reset(rst_n[2]), .bus_vaild(vld[2]), .bus_ready(rdy[2]), .bus_write_enable(wen[2]),
        .bus_address(adr[2]), .bus_read_data(rdat[2]), .bus_write_data(wdat[2]), .bus_error(err[2]));
    w80386_bus_ram_responder #(.WORD_ADDRESS_WIDTH(10), .BASE_ADDRESS(B3), .WAIT_STATES(WS3), .OPEN_BUS_DATA(OPEN)) u3 (
        .clock(clk), .reset(rst_n[3]), .bus_vaild(vld[3]), .bus_ready(rdy[3]), .bus_write_enable(wen[3]),
        .bus_address(adr[3]), .bus_read_data(rdat[3]), .bus_write_data(wdat[3]), .bus_error(err[3]));

    int unsigned ws_of   [N];
    logic [31:0] base_of [N];
    logic [31:0] model_mem   [N][DEPTH];
    bit          model_valid [N][DEPTH];
    logic [31:0] exp_rdata [N];
    bit          exp_known [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_in_window(input int i, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of[i];
        return (off / 4) < DEPTH;
    endfunction

    function automatic int model_word(input int i, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of[i];
        return int'((off / 4) % DEPTH);
    endfunction

    // Drive one request and count edges until ready is seen (called #1 after an edge)
    task automatic access(input int i, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output bit er, output logic [31:0] rd);
        vld[i] = 1'b1; wen[i] = we; adr[i] = a; wdat[i] = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (rdy[i] !== 1'b1 && lat < 40);
        er = err[i];
        rd = rdat[i];
        vld[i] = 1'b0;
    endtask

    task automatic model_access(input int i, input bit we, input logic [31:0] a, input logic [31:0] wd,
                                input string tag);
        int lat; bit er; logic [31:0] rd; bit inw; int w;
        inw = model_in_window(i, a);
        w   = model_word(i, a);
        access(i, we, a, wd, lat, er, rd);
        check({tag, ".latency"}, 32'(lat), 32'(ws_of[i] + 1));
        check({tag, ".error"}, 32'(er), 32'(!inw));
        if (!we) begin
            if (inw) begin
                exp_rdata[i] = model_mem[i][w];
                exp_known[i] = model_valid[i][w];
            end else begin
                exp_rdata[i] = OPEN;
                exp_known[i] = 1'b1;
            end
        end else if (inw) begin
            model_mem[i][w]   = wd;
            model_valid[i][w] = 1'b1;
        end
        if (exp_known[i]) check({tag, ".rdata"}, rd, exp_rdata[i]);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int k;
        logic [31:0] a_val;
        ws_of   = '{WS0, WS1, WS2, WS3};
        base_of = '{B0, B1, B2, B3};
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0; vld[i] = 1'b1; wen[i] = 1'b0;
            adr[i] = base_of[i]; wdat[i] = '0;
            exp_rdata[i] = '0; exp_known[i] = 1'b1;
        end

        // Reset held with a request pending: outputs stay quiet
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("reset.ready", 32'(rdy[0]), 32'd0);
            check("reset.error", 32'(err[0]), 32'd0);
            check("reset.rdata", rdat[0], 32'd0);
        end
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        for (int i = 1; i < N; i++) vld[i] = 1'b0;
        model_access(0, 1'b1, 32'h0000_0000, 32'h1234_5678, "reset_release");

        // Write then read, one wait state
        model_access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
        model_access(0, 1'b0, 32'h0000_0010, 32'h0, "rd10");
        check("rd10.const", rdat[0], 32'hDEAD_BEEF);
        model_access(0, 1'b0, 32'h0000_0013, 32'h0, "rd13");

        // Zero wait, back-to-back reads with bus_vaild held high
        for (int j = 0; j < 4; j++) model_access(1, 1'b1, 32'h20 + 32'(4 * j), $urandom, "b2b_fill");
        vld[1] = 1'b1; wen[1] = 1'b0; adr[1] = 32'h20; k = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("b2b.ready", 32'(rdy[1]), 32'((c % 2) == 0));
            if (rdy[1] === 1'b1 && k < 4) begin
                check("b2b.rdata", rdat[1], model_mem[1][8 + k]);
                k++;
                adr[1] = 32'h20 + 32'(4 * k);
                if (k == 4) vld[1] = 1'b0;
            end
        end
        vld[1] = 1'b0;
        exp_rdata[1] = model_mem[1][11]; exp_known[1] = 1'b1;

        // Window edges around BASE=0x1000, 1024 words
        model_access(2, 1'b1, 32'h0000_1FFC, 32'hA5A5_0001, "win.wr_top");
        model_access(2, 1'b0, 32'h0000_1FFC, 32'h0, "win.rd_top");
        model_access(2, 1'b0, 32'h0000_2000, 32'h0, "win.rd_above");
        check("win.open_const", rdat[2], 32'hFFFF_FFFF);
        model_access(2, 1'b1, 32'h0000_0FFC, 32'h5A5A_0002, "win.wr_below");
        model_access(2, 1'b0, 32'h0000_1FFC, 32'h0, "win.rd_top_again");

        // Reset pulsed while a write waits: no ready, old data survives
        model_access(2, 1'b1, 32'h0000_1100, 32'h1111_2222, "midrst.wr_old");
        vld[2] = 1'b1; wen[2] = 1'b1; adr[2] = 32'h0000_1100; wdat[2] = 32'h3333_4444;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("midrst.wait_ready", 32'(rdy[2]), 32'd0);
        end
        rst_n[2] = 1'b0; #1;
        check("midrst.rdata", rdat[2], 32'd0);
        vld[2] = 1'b0;
        @(posedge clk); #1;
        check("midrst.ready", 32'(rdy[2]), 32'd0);
        rst_n[2] = 1'b1;
        @(posedge clk); #1;
        check("midrst.after_ready", 32'(rdy[2]), 32'd0);
        exp_rdata[2] = '0; exp_known[2] = 1'b1;
        model_access(2, 1'b0, 32'h0000_1100, 32'h0, "midrst.rd_old");

        // Fifteen wait states, bus_vaild dropped briefly during WAIT
        vld[3] = 1'b1; wen[3] = 1'b1; adr[3] = 32'h44; wdat[3] = 32'hCAFE_F00D; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) vld[3] = 1'b0;
            if (lat == 6) vld[3] = 1'b1;
        end while (rdy[3] !== 1'b1 && lat < 40);
        check("maxwait.latency", 32'(lat), 32'd16);
        check("maxwait.error", 32'(err[3]), 32'd0);
        vld[3] = 1'b0;
        model_mem[3][17] = 32'hCAFE_F00D; model_valid[3][17] = 1'b1;
        @(posedge clk); #1;
        model_access(3, 1'b0, 32'h44, 32'h0, "maxwait.rd");

        // Random traffic on every configuration, including out-of-window hits
        for (int i = 0; i < N; i++) begin
            for (int n = 0; n < 50; n++) begin
                bit we;
                int sel;
                we  = 1'($urandom_range(0, 1));
                sel = int'($urandom_range(0, 7));
                if (sel == 0)
                    a_val = base_of[i] + 32'h1000 + 32'($urandom_range(0, 15) * 4);
                else if (sel == 1)
                    a_val = base_of[i] - 32'($urandom_range(1, 16));
                else
                    a_val = base_of[i] + 32'($urandom_range(0, 63));
                model_access(i, we, a_val, $urandom, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
